spi_lcd_ctrl: RTL and testbench
===============================

# spi_lcd_ctrl

Buffered, parametrised SPI master for the LCD panel interface. It accepts command and data words tagged with a D/C flag into an internal FIFO and serialises them in SPI mode 0, MSB first. Chip select stays asserted across back-to-back words, and the D/C line is driven per word. It replaces the single-byte path in the LCD display subsystem: the elevator display logic pushes words, and this block owns `cs`, `scl`, `sda` and `dc` to the panel.

## Interface
Parameters:
- `WORD_W`, default 8: bits per transferred word; legal range 1..32.
- `FIFO_DEPTH`, default 16: FIFO entries; power of 2, at least 2.
- `CLK_DIV`, default 4: `clk` cycles per SCL half-period; at least 1.

Ports:
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  push `{wr_dc, wr_data}` into the FIFO this cycle.
- `wr_dc`  in  1  D/C tag for the word: 0 = command, 1 = data.
- `wr_data`  in  WORD_W  word to send.
- `full`  out  1  FIFO holds FIFO_DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `level`  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- `overflow`  out  1  sticky flag; set when `wr_en` is high while `full` is high.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse after the last bit of each word.
- `cs`  out  1  chip select, active low.
- `scl`  out  1  serial clock; idles low.
- `sda`  out  1  serial data.
- `dc`  out  1  D/C line to the panel.

## Operation
- FIFO:
  - Synchronous, registered, entry width WORD_W+1.
  - A write while `full` is dropped and sets `overflow`. This holds even if a pop happens in the same cycle.
  - A simultaneous push and pop when not full leaves `level` unchanged.
  - `level`, `full` and `empty` update on the edge after a push or pop.
- FSM states: IDLE, SETUP, SHIFT, HOLD, GAP.
  - IDLE: `cs`=1, `scl`=0. When `empty`=0:
    - pop the head entry;
    - load the shift register, and drive `dc` = entry D/C and `sda` = entry MSB;
    - drive `cs`=0 and go to SETUP.
  - SETUP: hold for CLK_DIV cycles, then go to SHIFT.
  - SHIFT: each bit is CLK_DIV cycles with `scl`=1, then CLK_DIV cycles with `scl`=0.
    - `sda` advances to the next bit on the falling edge of `scl`.
    - The panel samples on the rising edge.
  - End of word (the last falling edge): pulse `done`.
    - If FIFO non-empty: pop the next entry in the same cycle, update `dc` and `sda`, and stay in SHIFT with `cs` still 0. There is no SETUP between words.
    - If FIFO empty: go to HOLD.
  - HOLD: `cs`=0 and `scl`=0 for CLK_DIV cycles, then drive `cs`=1 and go to GAP.
  - GAP: `cs`=1 for CLK_DIV cycles (minimum deselect time), then go to IDLE.
- `dc` holds its last value while in IDLE and changes only at a pop.
- Counters:
  - Half-period counter: $clog2(CLK_DIV+1) bits.
  - Bit counter: $clog2(WORD_W+1) bits, counting from WORD_W-1 down to 0. There is no wrap beyond the word.

## Timing
- Reset values: `cs`=1, `scl`=0, `sda`=0, `dc`=0, `busy`=0, `done`=0, `empty`=1, `full`=0, `level`=0, `overflow`=0. The FSM resets to IDLE and the FIFO is flushed.
- Assertion of `reset_n` mid-transfer:
  - aborts the transfer immediately and asynchronously, returning all outputs to their reset values;
  - discards the partially sent word.
- Latency from `wr_en` (into an empty FIFO, FSM in IDLE) to `cs` falling: 2 cycles. That is one cycle to write and one cycle to pop.
- Per word in SHIFT: 2·CLK_DIV·WORD_W cycles.
- Single isolated word:
  - `cs` low for CLK_DIV + 2·CLK_DIV·WORD_W + CLK_DIV cycles;
  - then `cs` high for at least CLK_DIV cycles before the next SETUP.
- N back-to-back words: `cs` low for 2·CLK_DIV + N·2·CLK_DIV·WORD_W cycles.
- `done` is high for exactly 1 cycle per word, coincident with the final `scl` falling edge.
- `busy` goes high the cycle `cs` falls and goes low on entry to IDLE.

## Test plan
- Reset: drive `reset_n`=0 with random inputs -> every output equals its reset value; `level`=0.
- Single word (WORD_W=8, CLK_DIV=2): push dc=0, data 0xA5 ->
  - `sda` at the 8 `scl` rising edges = 1,0,1,0,0,1,0,1;
  - `cs` low for 36 cycles; one `done` pulse; `dc`=0 throughout.
- Burst: push cmd 0x2A (dc=0), then data 0x00 and 0x10 (dc=1) ->
  - `cs` low continuously for 4 + 3·32 = 100 cycles;
  - `dc` rises at the first word boundary; three `done` pulses.
- Overflow (FIFO_DEPTH=4): push 5 words while IDLE is held off by prefill ->
  - `full`=1 after 4 pushes, the 5th word is dropped and `overflow`=1;
  - exactly 4 words appear on `sda`.
- Abort: drop `reset_n` in the middle of bit 3 of a word -> `cs`=1 and `scl`=0 immediately, FIFO empty, no `done`.
- Width/divider sweep: WORD_W=16, CLK_DIV=1, push 0x8001 -> 32-cycle SHIFT; `sda` is 1 on the first and last rising edges and 0 on the others.

Source files
------------

// File: rtl/spi_lcd_ctrl.sv
// Buffered SPI (mode 0, MSB first) master for the LCD panel.
// Words tagged with a D/C bit queue in a FIFO and go out back-to-back under one chip select.
module spi_lcd_ctrl #(
    parameter int WORD_W     = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int CLK_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          wr_en,
    input  logic                          wr_dc,
    input  logic [WORD_W-1:0]             wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   level,
    output logic                          overflow,
    output logic                          busy,
    output logic                          done,
    output logic                          cs,
    output logic                          scl,
    output logic                          sda,
    output logic                          dc
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(WORD_W + 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_MSB  = BW'(WORD_W - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    logic [WORD_W:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       count_q;
    logic              overflow_q;
    logic              push, pop;
    logic [WORD_W:0]   head;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [BW-1:0]     bit_q;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic              tail_q, cs_q, scl_q, sda_q, dc_q, done_q, busy_q;
    logic              half_end, last_fall;

    assign full      = (count_q == FULL_LVL);
    assign empty     = (count_q == '0);
    assign level     = count_q;
    assign overflow  = overflow_q;
    assign push      = wr_en && !full;
    assign head      = mem[rd_ptr_q];
    assign half_end  = (cnt_q == CNT_LAST);
    // Falling scl edge that ends the last bit of the current word.
    assign last_fall = (state_q == SHIFT) && scl_q && half_end && (bit_q == '0);
    assign pop       = !empty && ((state_q == IDLE) || last_fall);
    assign shift_d   = shift_q << 1;

    assign cs   = cs_q;
    assign scl  = scl_q;
    assign sda  = sda_q;
    assign dc   = dc_q;
    assign done = done_q;
    assign busy = busy_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {wr_dc, wr_data};
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (!push && pop) begin
                count_q <= count_q - 1'b1;
            end
            // A write against a full FIFO is lost even if a pop frees a slot this cycle.
            if (wr_en && full) overflow_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tail_q  <= 1'b0;
            cs_q    <= 1'b1;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
            dc_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (pop) begin
                shift_q <= head[WORD_W-1:0];
                sda_q   <= head[WORD_W-1];
                dc_q    <= head[WORD_W];
                bit_q   <= BIT_MSB;
            end
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q <= SETUP;
                        cs_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                SETUP: begin
                    if (half_end) begin
                        state_q <= SHIFT;
                        scl_q   <= 1'b1;
                        tail_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!half_end) begin
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        cnt_q <= '0;
                        if (scl_q) begin
                            scl_q <= 1'b0;
                            if (bit_q == '0) begin
                                done_q <= 1'b1;
                                tail_q <= empty;
                            end else begin
                                bit_q   <= bit_q - 1'b1;
                                shift_q <= shift_d;
                                sda_q   <= shift_d[WORD_W-1];
                            end
                        end else if (tail_q) begin
                            // Final low half-period finished with nothing queued.
                            state_q <= HOLD;
                        end else begin
                            scl_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        state_q <= GAP;
                        cs_q    <= 1'b1;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                GAP: begin
                    if (half_end) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_lcd_ctrl.sv
// Bench for spi_lcd_ctrl: a per-cycle reference model on an 8-bit/div-2/depth-4 instance,
// plus literal expectations on both that and a 16-bit/div-1 instance.
module tb_spi_lcd_ctrl;
    localparam int W = 8, D = 2, DEP = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic       wr_en = 0, wr_dc = 0;
    logic [7:0] wr_data = 0;
    logic       full_a, empty_a, ovf_a, busy_a, done_a, cs_a, scl_a, sda_a, dc_a;
    logic [2:0] level_a;

    logic        wr_en_b = 0, wr_dc_b = 0;
    logic [15:0] wr_data_b = 0;
    logic        full_b, empty_b, ovf_b, busy_b, done_b, cs_b, scl_b, sda_b, dc_b;
    logic [2:0]  level_b;

    spi_lcd_ctrl #(.WORD_W(8), .FIFO_DEPTH(4), .CLK_DIV(2)) dut_a (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_dc(wr_dc), .wr_data(wr_data),
        .full(full_a), .empty(empty_a), .level(level_a), .overflow(ovf_a), .busy(busy_a),
        .done(done_a), .cs(cs_a), .scl(scl_a), .sda(sda_a), .dc(dc_a));

    spi_lcd_ctrl #(.WORD_W(16), .FIFO_DEPTH(4), .CLK_DIV(1)) dut_b (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en_b), .wr_dc(wr_dc_b), .wr_data(wr_data_b),
        .full(full_b), .empty(empty_b), .level(level_b), .overflow(ovf_b), .busy(busy_b),
        .done(done_b), .cs(cs_b), .scl(scl_b), .sda(sda_b), .dc(dc_b));

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: r counts cycles relative to the first scl rise of the current word.
    logic [8:0] mq[$];
    int         m_r = 0;
    bit         m_act = 0, m_last = 0;
    logic [7:0] m_cur = 0;
    logic m_cs = 1, m_scl = 0, m_sda = 0, m_dc = 0, m_done = 0, m_busy = 0, m_ovf = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mq.delete();
            m_act = 0; m_last = 0; m_r = 0;
            m_cs = 1; m_scl = 0; m_sda = 0; m_dc = 0; m_done = 0; m_busy = 0; m_ovf = 0;
        end else begin
            bit was_full;
            logic [8:0] e;
            was_full = (mq.size() == DEP);
            m_done = 0;
            if (!m_act) begin
                if (mq.size() != 0) begin
                    e = mq.pop_front();
                    m_cur = e[7:0]; m_dc = e[8]; m_sda = e[7];
                    m_cs = 0; m_busy = 1; m_act = 1; m_last = 0; m_r = -D;
                end
            end else begin
                m_r++;
                if (m_r == 2*D*W - D) begin
                    m_done = 1;
                    if (mq.size() != 0) begin
                        e = mq.pop_front();
                        m_cur = e[7:0]; m_dc = e[8]; m_sda = e[7]; m_r = -D;
                    end else begin
                        m_last = 1;
                    end
                end else if (m_r > 0 && m_r < 2*D*W && (m_r % (2*D)) == D) begin
                    m_sda = m_cur[W - 2 - m_r / (2*D)];
                end
                if (m_last && m_r == 2*D*W + D) m_cs = 1;
                if (m_last && m_r == 2*D*W + 2*D) begin
                    m_act = 0; m_busy = 0;
                end
            end
            m_scl = m_act && m_r >= 0 && m_r < 2*D*W && (m_r % (2*D)) < D;
            if (wr_en) begin
                if (was_full) m_ovf = 1;
                else mq.push_back({wr_dc, wr_data});
            end
        end
    end

    always @(negedge clk) begin : cmp
        logic [11:0] a, e;
        a = {cs_a, scl_a, sda_a, dc_a, done_a, busy_a, full_a, empty_a, ovf_a, level_a};
        e = {m_cs, m_scl, m_sda, m_dc, m_done, m_busy, mq.size() == DEP, mq.size() == 0,
             m_ovf, 3'(mq.size())};
        check("model_cycle", 64'(a), 64'(e));
    end

    // Bus monitors: bits captured at scl rise, cs-low run lengths, done and scl-high counts.
    logic [63:0] bits_a = 0, bits_b = 0;
    int nbits_a = 0, cs_run_a = 0, last_cs_a = 0, ndone_a = 0;
    int nbits_b = 0, cs_run_b = 0, last_cs_b = 0, ndone_b = 0, sclhi_b = 0;
    logic prev_scl_a = 0, prev_scl_b = 0;

    always @(negedge clk) begin
        if (scl_a && !prev_scl_a) begin bits_a = {bits_a[62:0], sda_a}; nbits_a++; end
        prev_scl_a = scl_a;
        if (!cs_a) cs_run_a++;
        else if (cs_run_a != 0) begin last_cs_a = cs_run_a; cs_run_a = 0; end
        if (done_a) ndone_a++;
        if (scl_b && !prev_scl_b) begin bits_b = {bits_b[62:0], sda_b}; nbits_b++; end
        prev_scl_b = scl_b;
        if (scl_b) sclhi_b++;
        if (!cs_b) cs_run_b++;
        else if (cs_run_b != 0) begin last_cs_b = cs_run_b; cs_run_b = 0; end
        if (done_b) ndone_b++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_a(input logic d, input logic [7:0] v);
        wr_en = 1; wr_dc = d; wr_data = v;
        tick();
        wr_en = 0;
    endtask

    task automatic wait_busy_a();
        int n = 0;
        while (!busy_a && n < 20) begin tick(); n++; end
        check("busy_a_rises", 64'(busy_a), 64'd1);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 2000) begin tick(); n++; end
        check("busy_a_falls", 64'(busy_a), 64'd0);
        repeat (3) tick();
    endtask

    initial begin
        int nd0, n0;
        // Reset with random inputs
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'($urandom); wr_dc = 1'($urandom); wr_data = 8'($urandom);
            wr_en_b = 1'($urandom); wr_data_b = 16'($urandom);
            tick();
        end
        check("reset_a_outputs",
              64'({cs_a, scl_a, sda_a, dc_a, done_a, busy_a, full_a, empty_a, ovf_a, level_a}),
              64'h810);
        check("reset_b_outputs",
              64'({cs_b, scl_b, sda_b, dc_b, done_b, busy_b, full_b, empty_b, ovf_b, level_b}),
              64'h810);
        wr_en = 0; wr_en_b = 0; wr_dc = 0; wr_data = 0;
        tick();
        reset_n = 1;
        repeat (3) tick();

        // Single word 0xA5, command
        nd0 = ndone_a;
        push_a(0, 8'hA5);
        wait_busy_a();
        wait_idle_a();
        check("single_bits", bits_a[7:0], 64'hA5);
        check("single_cs_low", 64'(last_cs_a), 64'd36);
        check("single_done", 64'(ndone_a - nd0), 64'd1);
        check("single_dc", 64'(dc_a), 64'd0);

        // Burst: command then two data words
        nd0 = ndone_a;
        push_a(0, 8'h2A);
        push_a(1, 8'h00);
        push_a(1, 8'h10);
        wait_busy_a();
        wait_idle_a();
        check("burst_bits", bits_a[23:0], 64'h2A0010);
        check("burst_cs_low", 64'(last_cs_a), 64'd100);
        check("burst_done", 64'(ndone_a - nd0), 64'd3);
        check("burst_dc", 64'(dc_a), 64'd1);

        // Overflow: prefill keeps the FSM shifting while five words arrive
        nd0 = ndone_a;
        push_a(1, 8'h3C);
        wait_busy_a();
        push_a(0, 8'h11);
        push_a(0, 8'h22);
        push_a(0, 8'h33);
        push_a(0, 8'h44);
        check("ovf_full", 64'({full_a, level_a}), 64'hC);
        check("ovf_not_yet", 64'(ovf_a), 64'd0);
        push_a(0, 8'h55);
        check("ovf_set", 64'({ovf_a, level_a}), 64'hC);
        wait_idle_a();
        check("ovf_bits", bits_a[39:0], 64'h3C11223344);
        check("ovf_done", 64'(ndone_a - nd0), 64'd5);
        check("ovf_sticky", 64'(ovf_a), 64'd1);

        // Abort during bit 3 with a second word still queued
        push_a(0, 8'hF0);
        push_a(1, 8'h0F);
        n0 = nbits_a;
        nd0 = ndone_a;
        for (int i = 0; i < 200 && nbits_a < n0 + 4; i++) tick();
        check("abort_reached_bit3", 64'(nbits_a - n0), 64'd4);
        #1 reset_n = 0;
        #1;
        check("abort_outputs",
              64'({cs_a, scl_a, sda_a, dc_a, done_a, busy_a, full_a, empty_a, ovf_a, level_a}),
              64'h810);
        tick();
        tick();
        reset_n = 1;
        repeat (60) tick();
        check("abort_no_done", 64'(ndone_a - nd0), 64'd0);
        check("abort_idle", 64'({cs_a, empty_a, busy_a}), 64'b110);

        // Width/divider sweep on the 16-bit, div-1 instance
        nd0 = ndone_b;
        n0 = sclhi_b;
        wr_en_b = 1; wr_dc_b = 1; wr_data_b = 16'h8001;
        tick();
        wr_en_b = 0;
        for (int i = 0; i < 20 && !busy_b; i++) tick();
        check("sweep_busy", 64'(busy_b), 64'd1);
        for (int i = 0; i < 200 && busy_b; i++) tick();
        check("sweep_idle", 64'(busy_b), 64'd0);
        check("sweep_bits", bits_b[15:0], 64'h8001);
        check("sweep_cs_low", 64'(last_cs_b), 64'd34);
        check("sweep_scl_high", 64'(sclhi_b - n0), 64'd16);
        check("sweep_done", 64'(ndone_b - nd0), 64'd1);
        check("sweep_dc", 64'(dc_b), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
